// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch with a request/ack memory handshake, retry on
//             timeout, instruction hold and jump/branch next-PC selection.
//             Define FETCH_BNE_EN to add BNE (opcode 6'b000101) branch decode.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ex_done,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] br_offset;
    logic [31:0] next_pc;
    logic        br_taken;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign opcode    = instr_q[31:26];
    assign func      = instr_q[5:0];

`ifdef FETCH_BNE_EN
    assign br_taken = branch & (((opcode == 6'b000100) &  zero) |
                                ((opcode == 6'b000101) & ~zero));
`else
    assign br_taken = branch & zero;
`endif

    always_comb begin
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (br_taken) begin
            next_pc = pc_plus4 + br_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // req_q is asserted on entry to FETCH, so the request pulse lasts exactly
    // one cycle; straight out of reset FETCH idles one cycle to raise it.
    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                cnt_d = 8'd0;
                if (req_q) begin
                    state_d = S_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (ex_done) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    valid_d   = 1'b0;
                    req_d     = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b0;
            cnt_q     <= 8'd0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule
`default_nettype wire
